// File: rtl/csp_channel_if.sv
// Handshake bundle for csp_channel: bundled-data sender side (s_*), receiver side (r_*)
// and the channel occupancy. master = surrounding producer/consumer, slave = the channel.
interface csp_channel_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             s_req;
    logic             s_ack;
    logic [WIDTH-1:0] s_data;
    logic             r_req;
    logic             r_ack;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] count;

    modport master (
        output s_req, s_data, r_ack,
        input  s_ack, r_req, r_data, count
    );

    modport slave (
        input  s_req, s_data, r_ack,
        output s_ack, r_req, r_data, count
    );
endinterface

// File: rtl/csp_channel.sv
// Clocked CSP channel: bundled-data sender FSM -> DEPTH-entry FIFO -> receiver FSM,
// 4-phase (PROTOCOL=0) or 2-phase (PROTOCOL=1) handshakes on both sides.
module csp_channel #(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 2,
    parameter int PROTOCOL = 0
) (
    input  logic         clk,
    input  logic         reset,
    csp_channel_if.slave ch
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic       {S_IDLE, S_RTZ}         s_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RTZ} r_state_t;

    s_state_t         s_state;
    r_state_t         r_state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             s_ack_q;
    logic             r_req_q;
    logic [WIDTH-1:0] r_data_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // full looks only at the registered count, so a same-cycle pop never frees a slot early
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (PROTOCOL == 0) begin
            push = (s_state == S_IDLE) && ch.s_req && !full;
            pop  = (r_state == R_WAIT) && ch.r_ack;
        end else begin
            push = (ch.s_req != s_ack_q) && !full;
            pop  = (r_state == R_WAIT) && (ch.r_ack == r_req_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_state <= S_IDLE;
            s_ack_q <= 1'b0;
        end else if (PROTOCOL == 0) begin
            case (s_state)
                S_IDLE: if (push) begin
                    s_ack_q <= 1'b1;
                    s_state <= S_RTZ;
                end
                S_RTZ: if (!ch.s_req) begin
                    s_ack_q <= 1'b0;
                    s_state <= S_IDLE;
                end
                default: s_state <= S_IDLE;
            endcase
        end else if (push) begin
            s_ack_q <= ~s_ack_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= R_IDLE;
            r_req_q  <= 1'b0;
            r_data_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (!empty) begin
                    r_data_q <= mem[rd_ptr];
                    r_req_q  <= (PROTOCOL == 0) ? 1'b1 : ~r_req_q;
                    r_state  <= R_WAIT;
                end
                R_WAIT: if (pop) begin
                    if (PROTOCOL == 0) begin
                        r_req_q <= 1'b0;
                        r_state <= R_RTZ;
                    end else begin
                        r_state <= R_IDLE;
                    end
                end
                R_RTZ: if (!ch.r_ack) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ch.s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign ch.s_ack  = s_ack_q;
    assign ch.r_req  = r_req_q;
    assign ch.r_data = r_data_q;
    assign ch.count  = count_q;
endmodule

// File: tb/tb_csp_channel.sv
// Self-checking bench for csp_channel: four channel configurations driven by randomized
// producer/consumer tasks, checked against an ordered token queue.
module tb_csp_channel;
    localparam int W     = 12;
    localparam int NCH   = 4;   // ch0: D2/P0, ch1: D2/P1, ch2: D1/P0, ch3: D3/P0
    localparam int S_ACK = 0;
    localparam int R_REQ = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         s_req_v  [NCH];
    logic [W-1:0] s_data_v [NCH];
    logic         r_ack_v  [NCH];
    logic         s_ack_w  [NCH];
    logic         r_req_w  [NCH];
    logic [W-1:0] r_data_w [NCH];
    logic [3:0]   count_w  [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int D = (g == 2) ? 1 : (g == 3) ? 3 : 2;
        localparam int P = (g == 1) ? 1 : 0;

        csp_channel_if #(.WIDTH(W), .DEPTH(D)) ch_if ();

        assign ch_if.s_req  = s_req_v[g];
        assign ch_if.s_data = s_data_v[g];
        assign ch_if.r_ack  = r_ack_v[g];
        assign s_ack_w[g]   = ch_if.s_ack;
        assign r_req_w[g]   = ch_if.r_req;
        assign r_data_w[g]  = ch_if.r_data;
        assign count_w[g]   = 4'(ch_if.count);

        csp_channel #(.WIDTH(W), .DEPTH(D), .PROTOCOL(P)) u_dut (
            .clk   (clk),
            .reset (reset),
            .ch    (ch_if)
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q [$];   // tokens offered and not yet delivered, in order

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_sig(input int k, input int id);
        return (id == S_ACK) ? s_ack_w[k] : r_req_w[k];
    endfunction

    task automatic wait_for(input int k, input int id, input logic val, input string tag);
        for (int i = 0; i < 1000 && get_sig(k, id) !== val; i++) @(negedge clk);
        check(tag, get_sig(k, id), val);
    endtask

    task automatic check_token(input int k);
        if (exp_q.size() == 0) check("token_expected", exp_q.size(), 1);
        else check("r_data", r_data_w[k], exp_q.pop_front());
    endtask

    task automatic send4(input int k, input logic [W-1:0] v);
        exp_q.push_back(v);
        s_data_v[k] = v;
        s_req_v[k]  = 1'b1;
        @(negedge clk);
        wait_for(k, S_ACK, 1'b1, "s_ack_rise");
        s_req_v[k] = 1'b0;
        @(negedge clk);
        wait_for(k, S_ACK, 1'b0, "s_ack_fall");
    endtask

    task automatic send2(input int k, input logic [W-1:0] v);
        exp_q.push_back(v);
        s_data_v[k] = v;
        s_req_v[k]  = ~s_req_v[k];
        @(negedge clk);
        wait_for(k, S_ACK, s_req_v[k], "s_ack_toggle");
    endtask

    task automatic recv4(input int k, input int max_delay);
        wait_for(k, R_REQ, 1'b1, "r_req_rise");
        check_token(k);
        repeat ($urandom_range(max_delay, 0)) @(negedge clk);
        r_ack_v[k] = 1'b1;
        @(negedge clk);
        wait_for(k, R_REQ, 1'b0, "r_req_fall");
        r_ack_v[k] = 1'b0;
    endtask

    task automatic recv2(input int k, input int max_delay);
        wait_for(k, R_REQ, ~r_ack_v[k], "r_req_toggle");
        check_token(k);
        repeat ($urandom_range(max_delay, 0)) @(negedge clk);
        r_ack_v[k] = r_req_w[k];
        @(negedge clk);
    endtask

    task automatic drive_idle();
        for (int k = 0; k < NCH; k++) begin
            s_req_v[k]  = 1'b0;
            s_data_v[k] = '0;
            r_ack_v[k]  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] seq1 [7];
        seq1 = '{12'd14, 12'd5, 12'd118, 12'd51, 12'd27, 12'd8, 12'd77};
        drive_idle();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            check("rst_s_ack", s_ack_w[k], 0);
            check("rst_r_req", r_req_w[k], 0);
            check("rst_r_data", r_data_w[k], 0);
            check("rst_count", count_w[k], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // latency: ack one edge after s_req, cut-through r_req one edge after the write
        exp_q.push_back(12'd300);
        s_data_v[0] = 12'd300;
        s_req_v[0]  = 1'b1;
        @(negedge clk);
        check("ack_latency", s_ack_w[0], 1);
        check("count_after_write", count_w[0], 1);
        s_req_v[0] = 1'b0;
        @(negedge clk);
        check("cut_through_r_req", r_req_w[0], 1);
        check("cut_through_r_data", r_data_w[0], 300);
        check("ack_rtz", s_ack_w[0], 0);
        recv4(0, 0);

        // ideal receiver, fixed sequence
        fork
            for (int i = 0; i < 7; i++) send4(0, seq1[i]);
            repeat (7) recv4(0, 0);
        join
        repeat (2) @(negedge clk);
        check("seq_count_zero", count_w[0], 0);
        check("r_data_hold", r_data_w[0], 77);

        // stalled receiver: two tokens fill the FIFO, the third is back-pressured
        send4(0, 12'd200);
        send4(0, 12'd201);
        @(negedge clk);
        check("stall_count", count_w[0], 2);
        exp_q.push_back(12'd202);
        s_data_v[0] = 12'd202;
        s_req_v[0]  = 1'b1;
        repeat (3) @(negedge clk);
        check("backpressure_s_ack", s_ack_w[0], 0);
        check("stall_count_full", count_w[0], 2);
        fork
            begin
                wait_for(0, S_ACK, 1'b1, "ack_after_release");
                s_req_v[0] = 1'b0;
                @(negedge clk);
                wait_for(0, S_ACK, 1'b0, "ack_rtz_after_release");
            end
            repeat (3) recv4(0, 1);
        join
        repeat (2) @(negedge clk);
        check("stall_count_zero", count_w[0], 0);

        // asynchronous reset mid-transfer
        exp_q.push_back(12'd99);
        s_data_v[0] = 12'd99;
        s_req_v[0]  = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_r_req", r_req_w[0], 1);
        check("pre_reset_count", count_w[0], 1);
        check("pre_reset_s_ack", s_ack_w[0], 1);
        reset = 1'b1;
        #1;
        check("async_rst_s_ack", s_ack_w[0], 0);
        check("async_rst_r_req", r_req_w[0], 0);
        check("async_rst_count", count_w[0], 0);
        drive_idle();
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fork
            send4(0, 12'd27);
            recv4(0, 0);
        join
        repeat (5) @(negedge clk);
        check("post_reset_no_replay", r_req_w[0], 0);
        check("post_reset_count", count_w[0], 0);
        check("post_reset_r_data", r_data_w[0], 27);

        // 2-phase: one s_ack toggle per token, r_req toggles twice overall
        fork
            begin
                send2(1, 12'd5);
                check("p1_s_ack_first", s_ack_w[1], 1);
                send2(1, 12'd118);
                check("p1_s_ack_second", s_ack_w[1], 0);
            end
            repeat (2) recv2(1, 0);
        join
        repeat (3) @(negedge clk);
        check("p1_r_req_final", r_req_w[1], 0);
        check("p1_r_data_hold", r_data_w[1], 118);
        check("p1_count_zero", count_w[1], 0);

        // DEPTH=1: pop and new s_req in the same cycle defers the push by one edge
        send4(2, 12'd41);
        wait_for(2, R_REQ, 1'b1, "d1_r_req");
        check_token(2);
        exp_q.push_back(12'd42);
        r_ack_v[2]  = 1'b1;
        s_data_v[2] = 12'd42;
        s_req_v[2]  = 1'b1;
        @(negedge clk);
        check("d1_push_deferred", s_ack_w[2], 0);
        check("d1_count_after_pop", count_w[2], 0);
        @(negedge clk);
        check("d1_push_done", s_ack_w[2], 1);
        check("d1_count_after_push", count_w[2], 1);
        s_req_v[2] = 1'b0;
        r_ack_v[2] = 1'b0;
        @(negedge clk);
        wait_for(2, S_ACK, 1'b0, "d1_ack_rtz");
        recv4(2, 0);
        repeat (2) @(negedge clk);
        check("d1_count_zero", count_w[2], 0);

        // DEPTH=3 wrap-around with a random-delay receiver
        fork
            for (int i = 0; i < 10; i++) begin
                send4(3, W'(i));
                repeat ($urandom_range(1, 0)) @(negedge clk);
            end
            repeat (10) recv4(3, 4);
        join
        repeat (2) @(negedge clk);
        check("d3_count_zero", count_w[3], 0);

        // random data and timing on both protocols
        for (int k = 0; k < 2; k++) begin
            fork
                for (int i = 0; i < 20; i++) begin
                    if (k == 1) send2(k, W'($urandom));
                    else        send4(k, W'($urandom));
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                end
                repeat (20) begin
                    if (k == 1) recv2(k, 3);
                    else        recv4(k, 3);
                end
            join
            repeat (3) @(negedge clk);
            check("rand_count_zero", count_w[k], 0);
            check("rand_queue_drained", exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
